// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith/compare ops plus a WIDTH-cycle
// shift-add multiply behind a start/busy/done handshake.
module alu_seq #(
  parameter int WIDTH      = 8,
  parameter bit SIGNED_CMP = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op_code,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  output logic [WIDTH-1:0] result,
  output logic             zero_flag,
  output logic             carry_flag,
  output logic             overflow_flag,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_MUL = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0110;
  localparam logic [3:0] OP_OR  = 4'b0111;
  localparam logic [3:0] OP_ZT  = 4'b1001;
  localparam logic [3:0] OP_GT  = 4'b1010;
  localparam logic [3:0] OP_EQ  = 4'b1011;
  localparam logic [3:0] OP_LT  = 4'b1100;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 zero_q, zero_d;
  logic                 carry_q, carry_d;
  logic                 ovf_q, ovf_d;
  logic                 done_q, done_d;

  logic [WIDTH:0]       sum, diff;
  logic                 gt, lt;
  logic [WIDTH-1:0]     alu_res;
  logic                 alu_c, alu_o;
  logic [2*WIDTH-1:0]   acc_nxt;

  // Single-cycle datapath, fed straight from the live operands.
  always_comb begin
    sum  = {1'b0, data1} + {1'b0, data2};
    diff = {1'b0, data1} + {1'b0, ~data2} + (WIDTH+1)'(1);
    if (SIGNED_CMP) begin
      gt = $signed(data1) > $signed(data2);
      lt = $signed(data1) < $signed(data2);
    end else begin
      gt = data1 > data2;
      lt = data1 < data2;
    end
    alu_res = '0;
    alu_c   = 1'b0;
    alu_o   = 1'b0;
    case (op_code)
      OP_ADD: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_o   = (data1[WIDTH-1] == data2[WIDTH-1]) && (sum[WIDTH-1] != data1[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff[WIDTH-1:0];
        alu_c   = ~diff[WIDTH];  // no carry out of A+~B+1 means a borrow
        alu_o   = (data1[WIDTH-1] != data2[WIDTH-1]) && (diff[WIDTH-1] != data1[WIDTH-1]);
      end
      OP_AND:  alu_res = data1 & data2;
      OP_OR:   alu_res = data1 | data2;
      OP_ZT:   alu_res = WIDTH'(data1 == '0);
      OP_GT:   alu_res = WIDTH'(gt);
      OP_EQ:   alu_res = WIDTH'(data1 == data2);
      OP_LT:   alu_res = WIDTH'(lt);
      default: alu_res = '0;
    endcase
  end

  assign acc_nxt = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    result_d = result_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op_code == OP_MUL) begin
            mcand_d  = {{WIDTH{1'b0}}, data1};
            mplier_d = data2;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = S_MUL;
          end else begin
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            carry_d  = alu_c;
            ovf_d    = alu_o;
            done_d   = 1'b1;
          end
        end
      end
      S_MUL: begin
        acc_d    = acc_nxt;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          result_d = acc_nxt[WIDTH-1:0];
          zero_d   = (acc_nxt[WIDTH-1:0] == '0);
          carry_d  = 1'b0;
          ovf_d    = |acc_nxt[2*WIDTH-1:WIDTH];
          done_d   = 1'b1;
          cnt_d    = '0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  assign result        = result_q;
  assign zero_flag     = zero_q;
  assign carry_flag    = carry_q;
  assign overflow_flag = ovf_q;
  assign busy          = (state_q == S_MUL);
  assign done          = done_q;
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: three configurations (8u, 8s, 16u) share one
// stimulus stream; an arithmetic reference model predicts each completion.
module tb_alu_seq;
  localparam int NI = 3;
  localparam int WS[NI] = '{8, 8, 16};
  localparam bit SC[NI] = '{1'b0, 1'b1, 1'b0};

  typedef struct {
    logic [15:0] res;
    logic        z, c, o;
    longint      acc;
    longint      lat;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset, start;
  logic [3:0]  op_code;
  logic [15:0] d1, d2;
  logic [7:0]  r0, r1;
  logic [15:0] r2;
  logic [NI-1:0] zf, cf, of, bz, dn;
  logic [15:0] act_res [NI];

  int     tests = 0, fails = 0;
  longint cyc = 0;
  bit     rst_seen = 1'b0;
  int     mbusy [NI];
  exp_t   sb [NI][$];

  always #5 clock = ~clock;

  alu_seq #(.WIDTH(8), .SIGNED_CMP(1'b0)) u0 (
    .clock(clock), .reset(reset), .start(start), .op_code(op_code),
    .data1(d1[7:0]), .data2(d2[7:0]), .result(r0), .zero_flag(zf[0]),
    .carry_flag(cf[0]), .overflow_flag(of[0]), .busy(bz[0]), .done(dn[0]));
  alu_seq #(.WIDTH(8), .SIGNED_CMP(1'b1)) u1 (
    .clock(clock), .reset(reset), .start(start), .op_code(op_code),
    .data1(d1[7:0]), .data2(d2[7:0]), .result(r1), .zero_flag(zf[1]),
    .carry_flag(cf[1]), .overflow_flag(of[1]), .busy(bz[1]), .done(dn[1]));
  alu_seq #(.WIDTH(16), .SIGNED_CMP(1'b0)) u2 (
    .clock(clock), .reset(reset), .start(start), .op_code(op_code),
    .data1(d1), .data2(d2), .result(r2), .zero_flag(zf[2]),
    .carry_flag(cf[2]), .overflow_flag(of[2]), .busy(bz[2]), .done(dn[2]));

  assign act_res[0] = {8'h00, r0};
  assign act_res[1] = {8'h00, r1};
  assign act_res[2] = r2;

  // Reference: plain integer arithmetic on masked operands.
  function automatic exp_t model(int w, bit sc, logic [3:0] op, logic [15:0] a, logic [15:0] b);
    exp_t   e;
    longint m  = (longint'(1) << w) - 1;
    longint ua = longint'(a) & m;
    longint ub = longint'(b) & m;
    longint sa = (ua >> (w - 1)) & 1;
    longint sb_ = (ub >> (w - 1)) & 1;
    longint va = (sa != 0) ? ua - (m + 1) : ua;
    longint vb = (sb_ != 0) ? ub - (m + 1) : ub;
    longint t = 0, r = 0, c = 0, o = 0, sr;
    case (op)
      4'h1: begin t = ua + ub; r = t & m; c = t >> w;
                  sr = (r >> (w - 1)) & 1; o = (sa == sb_ && sr != sa) ? 1 : 0; end
      4'h2: begin t = ua - ub; r = t & m; c = (ua < ub) ? 1 : 0;
                  sr = (r >> (w - 1)) & 1; o = (sa != sb_ && sr != sa) ? 1 : 0; end
      4'h3: begin t = ua * ub; r = t & m; o = ((t >> w) != 0) ? 1 : 0; end
      4'h6: r = ua & ub;
      4'h7: r = ua | ub;
      4'h9: r = (ua == 0) ? 1 : 0;
      4'hA: r = sc ? ((va > vb) ? 1 : 0) : ((ua > ub) ? 1 : 0);
      4'hB: r = (ua == ub) ? 1 : 0;
      4'hC: r = sc ? ((va < vb) ? 1 : 0) : ((ua < ub) ? 1 : 0);
      default: r = 0;
    endcase
    e.res = r[15:0];
    e.z   = (r == 0);
    e.c   = c[0];
    e.o   = o[0];
    e.acc = 0;
    e.lat = 0;
    return e;
  endfunction

  task automatic chk(string nm, int i, logic [15:0] act, logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d cycle %0d: got %h expected %h", nm, i, cyc, act, exp);
    end
  endtask

  // Model side: sees the same inputs as the DUTs at each rising edge.
  always @(posedge clock) begin
    exp_t e;
    cyc++;
    rst_seen = reset;
    for (int i = 0; i < NI; i++) begin
      if (reset) begin
        mbusy[i] = 0;
        sb[i].delete();
      end else if (mbusy[i] > 0) begin
        mbusy[i]--;
      end else if (start) begin
        e = model(WS[i], SC[i], op_code, d1, d2);
        e.acc = cyc;
        e.lat = (op_code == 4'h3) ? WS[i] : 0;
        sb[i].push_back(e);
        if (op_code == 4'h3) mbusy[i] = WS[i];
      end
    end
  end

  // Monitor: compares on the falling edge, away from the DUT update.
  always @(negedge clock) begin
    exp_t e;
    if (cyc > 0) begin
      for (int i = 0; i < NI; i++) begin
        if (rst_seen) begin
          chk("rst_result", i, act_res[i], 16'h0);
          chk("rst_zero", i, 16'(zf[i]), 16'h1);
          chk("rst_carry", i, 16'(cf[i]), 16'h0);
          chk("rst_ovf", i, 16'(of[i]), 16'h0);
          chk("rst_done", i, 16'(dn[i]), 16'h0);
        end
        chk("busy", i, 16'(bz[i]), 16'(mbusy[i] > 0));
        if (dn[i]) begin
          if (sb[i].size() == 0) begin
            chk("spurious_done", i, 16'(dn[i]), 16'h0);
          end else begin
            e = sb[i].pop_front();
            chk("latency", i, 16'(cyc - e.acc), 16'(e.lat));
            chk("result", i, act_res[i], e.res);
            chk("zero", i, 16'(zf[i]), 16'(e.z));
            chk("carry", i, 16'(cf[i]), 16'(e.c));
            chk("ovf", i, 16'(of[i]), 16'(e.o));
          end
        end else if (sb[i].size() > 0 && cyc >= sb[i][0].acc + sb[i][0].lat) begin
          chk("missing_done", i, 16'(dn[i]), 16'h1);
          void'(sb[i].pop_front());
        end
      end
    end
  end

  task automatic issue(logic [3:0] op, logic [15:0] a, logic [15:0] b);
    start = 1'b1; op_code = op; d1 = a; d2 = b;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic rst_pulse();
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [3:0] ops [10] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h6, 4'h7, 4'h9, 4'hA, 4'hB, 4'hC};
    for (int i = 0; i < NI; i++) mbusy[i] = 0;
    // Reset held two cycles with a live ADD request: must be dropped.
    reset = 1'b1; start = 1'b1; op_code = 4'h1; d1 = 16'd5; d2 = 16'd3;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0; start = 1'b0;
    idle(2);

    issue(4'h1, 16'h00FF, 16'h0001); idle(2);
    issue(4'h1, 16'h007F, 16'h0001); idle(1);
    issue(4'h1, 16'hFFFF, 16'h0001); idle(1);
    issue(4'h2, 16'h0003, 16'h0005); idle(1);
    issue(4'h2, 16'h8000, 16'h0001); idle(1);

    issue(4'h3, 16'h000F, 16'h0011); idle(18);
    issue(4'h3, 16'h0010, 16'h0010); idle(18);
    issue(4'h3, 16'h00AB, 16'h00CD); idle(3);
    issue(4'h1, 16'h0001, 16'h0001); idle(18);

    issue(4'hA, 16'h0080, 16'h0001);
    issue(4'hB, 16'h002A, 16'h002A);
    issue(4'hC, 16'h0000, 16'h0000);
    issue(4'h9, 16'h0000, 16'h0005);
    issue(4'hC, 16'h00FF, 16'h0001);
    idle(2);

    // Streaming with an illegal opcode in the middle.
    issue(4'h6, 16'h00F0, 16'h003C);
    issue(4'h7, 16'h00F0, 16'h000F);
    issue(4'hF, 16'h1234, 16'h5678);
    issue(4'hB, 16'h0055, 16'h0055);
    idle(2);

    // Abort a multiply at iteration 4, then run a fresh one.
    issue(4'h3, 16'h00FF, 16'h00FF); idle(3);
    rst_pulse();
    issue(4'h3, 16'h0003, 16'h0007); idle(18);
    issue(4'h3, 16'hFFFF, 16'h0002); idle(18);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 49) == 0) rst_pulse();
      issue(ops[$urandom_range(0, 9)], 16'($urandom), 16'($urandom));
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end

    idle(20);
    for (int i = 0; i < NI; i++) chk("drain", i, 16'(sb[i].size()), 16'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, sequential successor to the team's 8-bit single-cycle ALU. Adds a start/busy/done handshake, a configurable data width, separate carry and signed-overflow flags, a signed/unsigned compare mode and a multi-cycle shift-add multiply. It sits between the instruction decoder and the register-file writeback, and the decoder holds each new operation until `busy` is low.

## Interface
- `WIDTH`, default 8: operand and result width, ≥ 2.
- `SIGNED_CMP`, default 0: 0 makes GT/LT compare unsigned; 1 makes them compare two's-complement.

Ports, clock and reset first:
- `clock` input 1: the only clock; every register updates on its rising edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: operation request, sampled only in IDLE.
- `op_code` input 4: operation select, latched when `start` is accepted.
- `data1` input WIDTH: operand A, latched when `start` is accepted.
- `data2` input WIDTH: operand B, latched when `start` is accepted.
- `result` output WIDTH: registered result, held until the next completion.
- `zero_flag` output 1: registered, equals (`result` == 0) for the held result.
- `carry_flag` output 1: unsigned carry out (ADD) or borrow (SUB).
- `overflow_flag` output 1: signed overflow (ADD/SUB) or high-half-nonzero (MUL).
- `busy` output 1: high while a multiply is in progress.
- `done` output 1: one-cycle completion pulse.

## Operation
- Opcodes:
  - 0000 NOOP: `result`=0.
  - 0001 ADD.
  - 0010 SUB: computed as A + ~B + 1.
  - 0011 MUL: unsigned, multi-cycle.
  - 0110 AND.
  - 0111 OR.
  - 1001 ZERO_TEST: `result`=1 if A==0, else 0.
  - 1010 GT.
  - 1011 EQ.
  - 1100 LT.
  - Every unlisted opcode behaves exactly as NOOP, including asserting `done`.
- Compare and test results are zero-extended 0 or 1 in `result`.
- ADD:
  - The full sum is WIDTH+1 bits; `result` = sum[WIDTH-1:0] and `carry_flag` = sum[WIDTH].
  - `overflow_flag` = (A[msb]==B[msb]) && (result[msb]!=A[msb]).
- SUB:
  - `carry_flag` = 1 when A < B unsigned (borrow).
  - `overflow_flag` = (A[msb]!=B[msb]) && (result[msb]!=A[msb]).
- MUL:
  - Shift-add over WIDTH iterations into a 2·WIDTH-bit accumulator.
  - `result` = product[WIDTH-1:0]; `overflow_flag` = |product[2·WIDTH-1:WIDTH]; `carry_flag` = 0.
- All other operations clear `carry_flag` and `overflow_flag`.
- Flag registers and `zero_flag` update only on completion; between operations they hold.
- State machine:
  - IDLE: stays here while `start`=0.
    - `start`=1 with a non-MUL op: compute from the live inputs, register outputs, pulse `done`, remain in IDLE.
    - `start`=1 with MUL: latch A, B and clear the accumulator and iteration counter, go to MUL.
  - MUL: each cycle, if B[0] then acc += A<<i; B >>= 1; counter++. After the WIDTH-th iteration, register outputs, pulse `done`, return to IDLE.
- `start` while in MUL (`busy`=1) is ignored; it is not queued.
- Back-to-back single-cycle ops: `start` held high with new operands every cycle gives one completion per cycle.

## Timing
- Reset values: `result`=0, `zero_flag`=1, `carry_flag`=0, `overflow_flag`=0, `busy`=0, `done`=0, state=IDLE, counter=0.
- Single-cycle ops: `start` sampled at edge k; `result`, flags and `done`=1 are visible after edge k; `done` falls after edge k+1 unless another op completes then.
- MUL:
  - Accepted at edge k, with `busy`=1 after edge k.
  - The last iteration is at edge k+WIDTH; outputs and `done`=1 are visible after edge k+WIDTH, and `busy`=0 from that same edge.
  - Latency is WIDTH cycles; a new `start` is accepted at edge k+WIDTH+1 at the earliest.
- Reset mid-MUL:
  - The operation is aborted and no `done` is issued.
  - Outputs take their reset values at the next edge.
- Reset and `start` in the same cycle: reset wins and the operation is dropped.
- Operand or `op_code` changes during MUL have no effect on the running operation.

## Test plan
- Reset: hold `reset`=1 for 2 cycles with `start`=1, ADD 5+3 → `result`=0, `zero_flag`=1, `busy`=0, `done`=0 throughout.
- ADD/SUB flags (WIDTH=8):
  - ADD 0xFF+0x01 → `result`=0x00, `carry_flag`=1, `overflow_flag`=0, `zero_flag`=1, `done` pulses 1 cycle.
  - ADD 0x7F+0x01 → 0x80 with `overflow_flag`=1, `carry_flag`=0.
  - SUB 0x03−0x05 → 0xFE with `carry_flag`=1.
- MUL: 0x0F×0x11 → `result`=0xFF, `overflow_flag`=0, `done` exactly 8 cycles after accept. 0x10×0x10 → `result`=0x00, `overflow_flag`=1, `zero_flag`=1. A `start` with ADD issued mid-MUL → ignored, no extra `done`.
- Compare modes: GT 0x80 vs 0x01 → 1 with `SIGNED_CMP`=0, 0 with `SIGNED_CMP`=1. EQ 0x2A,0x2A → 1. LT 0x00,0x00 → 0. ZERO_TEST 0x00 → 1.
- Streaming and illegal ops: `start` held high for 4 cycles with AND, OR, opcode 1111, EQ → 4 consecutive `done` cycles; opcode 1111 gives `result`=0, `zero_flag`=1.
- Reset mid-MUL at iteration 4, then a MUL 3×7 → the first MUL produces no `done`; the second produces `result`=21 after WIDTH cycles. Repeat with WIDTH=16: 0xFFFF×0x0002 → 0xFFFE, `overflow_flag`=1, latency 16.
